// File: rtl/sid_filter_mc_pkg.sv
// Shared types, default widths and saturation helpers for the time-multiplexed
// SID state-variable filter (sid_filter_mc).
package sid_filter_mc_pkg;

  localparam int SID_CHANNELS = 2;
  localparam int SID_DATA_W   = 16;
  localparam int SID_W0_W     = 16;
  localparam int SID_W0_FRAC  = 17;
  localparam int SID_Q_W      = 11;
  localparam int SID_Q_FRAC   = 10;

  // One pipeline step per state; IDLE is the only state that accepts requests.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LP   = 3'd1,
    BP   = 3'd2,
    HP   = 3'd3,
    MIX  = 3'd4,
    OUT  = 3'd5
  } filt_state_e;

  // Integrator state of one filter instance at the default data width.
  typedef struct packed {
    logic signed [SID_DATA_W-1:0] vlp;
    logic signed [SID_DATA_W-1:0] vbp;
    logic signed [SID_DATA_W-1:0] vhp;
  } filt_chan_t;

  // Clamp x into the signed range of a w-bit word (w <= 31).
  function automatic int sat_int(input int x, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // True when sat_int(x, w) would clamp.
  function automatic logic sat_hit(input int x, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (x > hi) || (x < lo);
  endfunction

endpackage

// File: rtl/sid_filter_mc_mul.sv
// Combinational signed A_W x B_W multiplier shared by every filter step.
module sid_filter_mul #(
  parameter int A_W = 16,
  parameter int B_W = 16
) (
  input  logic signed [A_W-1:0]     a_i,
  input  logic signed [B_W-1:0]     b_i,
  output logic signed [A_W+B_W-1:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/sid_filter_mc.sv
// Time-multiplexed state-variable filter plus master-volume mixer for several
// SID chips. One request walks IDLE->LP->BP->HP->MIX->OUT using a single
// shared multiplier; per-channel vlp/vbp/vhp live in register arrays.
// Optional feature: define SID_FILTER_MC_SAT_FLAG_EN for sticky per-channel
// saturation flags on sat_o (tied to zero otherwise).
module sid_filter_mc
  import sid_filter_mc_pkg::*;
#(
  parameter int CHANNELS = SID_CHANNELS,
  parameter int DATA_W   = SID_DATA_W,
  parameter int W0_W     = SID_W0_W,
  parameter int W0_FRAC  = SID_W0_FRAC,
  parameter int Q_W      = SID_Q_W,
  parameter int Q_FRAC   = SID_Q_FRAC,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_vi,
  input  logic signed [DATA_W-1:0] in_vd,
  input  logic signed [W0_W-1:0]   in_w0,
  input  logic [Q_W-1:0]           in_q,
  input  logic [2:0]               in_mode,
  input  logic [3:0]               in_vol,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DATA_W+3:0] out_audio,
  output logic [CHANNELS-1:0]      sat_o
);

  // Sums are formed two bits wider than the state so a clamp can be detected.
  localparam int EXT_W = DATA_W + 2;
  localparam int A_W0  = (W0_W > Q_W + 1) ? W0_W : Q_W + 1;
  localparam int A_W   = (A_W0 > 5) ? A_W0 : 5;
  localparam int P_W   = A_W + DATA_W;
  localparam int OUT_W = DATA_W + 4;

  filt_state_e              state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic signed [DATA_W-1:0] vi_q, vi_d;
  logic signed [DATA_W-1:0] vd_q, vd_d;
  logic signed [W0_W-1:0]   w0_q, w0_d;
  logic [Q_W-1:0]           q_q, q_d;
  logic [2:0]               mode_q, mode_d;
  logic [3:0]               vol_q, vol_d;
  logic signed [DATA_W-1:0] m_q, m_d;
  logic                     out_valid_q, out_valid_d;
  logic [CH_W-1:0]          out_ch_q, out_ch_d;
  logic signed [OUT_W-1:0]  out_audio_q, out_audio_d;

  logic signed [DATA_W-1:0] vlp_q [CHANNELS];
  logic signed [DATA_W-1:0] vlp_d [CHANNELS];
  logic signed [DATA_W-1:0] vbp_q [CHANNELS];
  logic signed [DATA_W-1:0] vbp_d [CHANNELS];
  logic signed [DATA_W-1:0] vhp_q [CHANNELS];
  logic signed [DATA_W-1:0] vhp_d [CHANNELS];

  logic                     ch_ok;
  logic signed [DATA_W-1:0] cur_vlp, cur_vbp, cur_vhp;
  logic signed [A_W-1:0]    mul_a;
  logic signed [DATA_W-1:0] mul_b;
  logic signed [P_W-1:0]    mul_p;
  logic signed [P_W-1:0]    p_w0, p_q;
  logic signed [EXT_W-1:0]  term_lp, term_bp, term_hp;
  logic signed [EXT_W-1:0]  alu_x;
  logic signed [DATA_W-1:0] alu_y;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_audio = out_audio_q;
  assign ch_ok     = int'(ch_q) < CHANNELS;

  // Read the latched channel's state; out-of-range channels read as zero.
  always_comb begin
    cur_vlp = '0;
    cur_vbp = '0;
    cur_vhp = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(ch_q) == i) begin
        cur_vlp = vlp_q[i];
        cur_vbp = vbp_q[i];
        cur_vhp = vhp_q[i];
      end
    end
  end

  // Steer the shared multiplier: w0*vbp, w0*vhp(old), q*vbp(new), vol*m.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      LP: begin
        mul_a = A_W'(w0_q);
        mul_b = cur_vbp;
      end
      BP: begin
        mul_a = A_W'(w0_q);
        mul_b = cur_vhp;
      end
      HP: begin
        mul_a = A_W'({1'b0, q_q});
        mul_b = cur_vbp;
      end
      OUT: begin
        mul_a = A_W'({1'b0, vol_q});
        mul_b = m_q;
      end
      default: ;
    endcase
  end

  sid_filter_mul #(
    .A_W(A_W),
    .B_W(DATA_W)
  ) u_mul (
    .a_i(mul_a),
    .b_i(mul_b),
    .p_o(mul_p)
  );

  // Wide sum for the current step, then clamp back to DATA_W.
  always_comb begin
    p_w0    = mul_p >>> W0_FRAC;
    p_q     = mul_p >>> Q_FRAC;
    term_lp = '0;
    term_bp = '0;
    term_hp = '0;
    if (mode_q[0]) term_lp = EXT_W'(cur_vlp);
    if (mode_q[1]) term_bp = EXT_W'(cur_vbp);
    if (mode_q[2]) term_hp = EXT_W'(cur_vhp);
    alu_x = '0;
    case (state_q)
      LP:      alu_x = EXT_W'(cur_vlp) - EXT_W'(p_w0);
      BP:      alu_x = EXT_W'(cur_vbp) - EXT_W'(p_w0);
      HP:      alu_x = EXT_W'(p_q) - EXT_W'(cur_vlp) - EXT_W'(vi_q);
      MIX:     alu_x = EXT_W'(vd_q) + term_lp + term_bp + term_hp;
      default: alu_x = '0;
    endcase
    alu_y = DATA_W'(sat_int(int'(alu_x), DATA_W));
  end

  // Sequencer next state: latch on accept, write one integrator per step.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    vi_d        = vi_q;
    vd_d        = vd_q;
    w0_d        = w0_q;
    q_d         = q_q;
    mode_d      = mode_q;
    vol_d       = vol_q;
    m_d         = m_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_audio_d = out_audio_q;
    vlp_d       = vlp_q;
    vbp_d       = vbp_q;
    vhp_d       = vhp_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = LP;
          ch_d    = in_ch;
          vi_d    = in_vi;
          vd_d    = in_vd;
          w0_d    = in_w0;
          q_d     = in_q;
          mode_d  = in_mode;
          vol_d   = in_vol;
        end
      end
      LP: begin
        state_d = ch_ok ? BP : IDLE;
        for (int i = 0; i < CHANNELS; i++) begin
          if (int'(ch_q) == i) vlp_d[i] = alu_y;
        end
      end
      BP: begin
        state_d = HP;
        for (int i = 0; i < CHANNELS; i++) begin
          if (int'(ch_q) == i) vbp_d[i] = alu_y;
        end
      end
      HP: begin
        state_d = MIX;
        for (int i = 0; i < CHANNELS; i++) begin
          if (int'(ch_q) == i) vhp_d[i] = alu_y;
        end
      end
      MIX: begin
        state_d = OUT;
        m_d     = alu_y;
      end
      OUT: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_ch_d    = ch_q;
        out_audio_d = OUT_W'(mul_p);
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, latched request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      vi_q        <= '0;
      vd_q        <= '0;
      w0_q        <= '0;
      q_q         <= '0;
      mode_q      <= '0;
      vol_q       <= '0;
      m_q         <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_audio_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      vi_q        <= vi_d;
      vd_q        <= vd_d;
      w0_q        <= w0_d;
      q_q         <= q_d;
      mode_q      <= mode_d;
      vol_q       <= vol_d;
      m_q         <= m_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_audio_q <= out_audio_d;
    end
  end

  // Per-channel integrator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        vlp_q[i] <= '0;
        vbp_q[i] <= '0;
        vhp_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        vlp_q[i] <= vlp_d[i];
        vbp_q[i] <= vbp_d[i];
        vhp_q[i] <= vhp_d[i];
      end
    end
  end

`ifdef SID_FILTER_MC_SAT_FLAG_EN
  logic [CHANNELS-1:0] sat_q, sat_d;
  logic                alu_clamp;

  assign alu_clamp = sat_hit(int'(alu_x), DATA_W);
  assign sat_o     = sat_q;

  // Sticky clamp flags: a vol=0 accept clears its channel, any clamp sets it.
  always_comb begin
    sat_d = sat_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((state_q == IDLE) && in_valid && (in_vol == 4'd0) && (int'(in_ch) == i))
        sat_d[i] = 1'b0;
      if ((state_q != IDLE) && (state_q != OUT) && alu_clamp && (int'(ch_q) == i))
        sat_d[i] = 1'b1;
    end
  end

  // Saturation flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= '0;
    else        sat_q <= sat_d;
  end
`else
  assign sat_o = '0;
`endif

endmodule

// File: tb/tb_sid_filter_mc.sv
// Scoreboard bench for sid_filter_mc (CHANNELS=3): stimulus pushes expected
// results, a negedge monitor pops and compares on every out_valid.
module tb_sid_filter_mc;
  localparam int CHANNELS = 3;
  localparam int DATA_W   = 16;
  localparam int W0_W     = 16;
  localparam int Q_W      = 11;
  localparam int CH_W     = 2;
  localparam int OUT_W    = DATA_W + 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch = '0;
  logic signed [DATA_W-1:0] in_vi = '0;
  logic signed [DATA_W-1:0] in_vd = '0;
  logic signed [W0_W-1:0]   in_w0 = '0;
  logic [Q_W-1:0]           in_q = '0;
  logic [2:0]               in_mode = '0;
  logic [3:0]               in_vol = '0;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [OUT_W-1:0]  out_audio;
  logic [CHANNELS-1:0]      sat_o;

  always #5 clk = ~clk;

  sid_filter_mc #(
    .CHANNELS(CHANNELS),
    .DATA_W(DATA_W),
    .W0_W(W0_W),
    .W0_FRAC(17),
    .Q_W(Q_W),
    .Q_FRAC(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ch(in_ch),
    .in_vi(in_vi),
    .in_vd(in_vd),
    .in_w0(in_w0),
    .in_q(in_q),
    .in_mode(in_mode),
    .in_vol(in_vol),
    .out_valid(out_valid),
    .out_ch(out_ch),
    .out_audio(out_audio),
    .sat_o(sat_o)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int ch;
    int audio;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   cyc = 0;
  int   last_acc = -1;
  bit   b2b = 1'b0;

  longint m_vlp [CHANNELS];
  longint m_vbp [CHANNELS];
  longint m_vhp [CHANNELS];
  bit     m_sat [CHANNELS];
  bit     m_hit;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: floor division by 2^sh and clamp to 16-bit signed.
  function automatic longint fl(input longint a, input int sh);
    longint d;
    d = longint'(1) << sh;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic longint msat(input longint x);
    if (x > 32767) begin m_hit = 1'b1; return 32767; end
    if (x < -32768) begin m_hit = 1'b1; return -32768; end
    return x;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      m_vlp[i] = 0; m_vbp[i] = 0; m_vhp[i] = 0; m_sat[i] = 1'b0;
    end
  endfunction

  function automatic int model(input int ch, input int vi, input int vd, input int w0,
                               input int q, input int mode, input int vol);
    longint lp, bp, hp, m;
    if (vol == 0) m_sat[ch] = 1'b0;
    m_hit = 1'b0;
    lp = msat(m_vlp[ch] - fl(longint'(w0) * m_vbp[ch], 17));
    bp = msat(m_vbp[ch] - fl(longint'(w0) * m_vhp[ch], 17));
    hp = msat(fl(longint'(q) * bp, 10) - lp - vi);
    m  = vd;
    if (mode[0]) m += lp;
    if (mode[1]) m += bp;
    if (mode[2]) m += hp;
    m = msat(m);
    if (m_hit) m_sat[ch] = 1'b1;
    m_vlp[ch] = lp; m_vbp[ch] = bp; m_vhp[ch] = hp;
    return int'(m * vol);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record accepts and check each result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      if (int'(in_ch) < CHANNELS) lat_q.push_back(cyc + 1);
      if (b2b && last_acc >= 0) chk("accept_gap", cyc + 1 - last_acc, 6);
      last_acc = cyc + 1;
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_ch", out_ch, e.ch);
        chk("out_audio", out_audio, e.audio);
        if (lat_q.size() != 0) chk("latency", cyc - lat_q.pop_front(), 5);
      end
    end
  end

  // Issue one request; starts and ends just after a rising edge.
  task automatic send(input int ch, input int vi, input int vd, input int w0, input int q,
                      input int mode, input int vol, input bit keep,
                      input bit expect_out, input bit use_hand, input int hand);
    int  n;
    bit  got;
    exp_t e;
    if (expect_out && ch < CHANNELS) begin
      e.ch    = ch;
      e.audio = model(ch, vi, vd, w0, q, mode, vol);
      if (use_hand) e.audio = hand;
      exp_q.push_back(e);
    end
    in_ch    = CH_W'(ch);
    in_vi    = DATA_W'(vi);
    in_vd    = DATA_W'(vd);
    in_w0    = W0_W'(w0);
    in_q     = Q_W'(q);
    in_mode  = 3'(mode);
    in_vol   = 4'(vol);
    in_valid = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      n++;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
    $display("req ch=%0d vi=%0d vd=%0d w0=%0d q=%0d mode=%0d vol=%0d", ch, vi, vd, w0, q, mode, vol);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sat(input string nm);
    logic [CHANNELS-1:0] e;
    e = '0;
`ifdef SID_FILTER_MC_SAT_FLAG_EN
    for (int i = 0; i < CHANNELS; i++) e[i] = m_sat[i];
`endif
    @(negedge clk);
    chk(nm, sat_o, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_audio", out_audio, 0);
    chk("rst_sat_o", sat_o, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Build up state on ch1 so the abort-then-reset has something to clear.
    for (int k = 0; k < 3; k++) send(1, -1000, 0, 8192, 1024, 1, 15, 1'b0, 1'b1, 1'b0, 0);
    drain();

    // Abort a request mid-BP with reset: no result may appear.
    send(1, 3000, 100, 8192, 1024, 7, 15, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_sat_o", sat_o, 0);
    model_reset();
    lat_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    // Cleared state: vlp' = 0 so LP-only output is 0.
    send(1, -1000, 0, 8192, 1024, 1, 15, 1'b0, 1'b1, 1'b1, 0);

    // Impulse on ch0: vhp'=1000, then vbp'=-62, then vlp'=4 (floor(-3.875) = -4).
    send(0, -1000, 0, 8192, 1024, 4, 1, 1'b0, 1'b1, 1'b1, 1000);
    send(0, -1000, 0, 8192, 1024, 2, 1, 1'b0, 1'b1, 1'b1, -62);
    send(0, -1000, 0, 8192, 1024, 1, 15, 1'b0, 1'b1, 1'b1, 60);
    // vlp'=12 on top of vd=32767 clamps the mix: 15*32767.
    send(0, -1000, 32767, 8192, 1024, 1, 15, 1'b0, 1'b1, 1'b1, 491505);
    drain();
    chk_sat("sat_after_clamp");

    // Channel isolation: interleave ch1/ch2 with different coefficients.
    for (int k = 0; k < 8; k++) begin
      int ch;
      ch = 1 + (k % 2);
      send(ch, (ch == 1) ? -1500 : 700 + 300 * k, (k == 5) ? -32768 : 0,
           (ch == 1) ? 8192 : 20000, (ch == 1) ? 1024 : 1448,
           (k % 7) + 1, (k == 4) ? 0 : 9 + (k % 2) * 6, 1'b0, 1'b1, 1'b0, 0);
    end
    drain();
    chk_sat("sat_after_isolation");

    // Back-to-back requests with in_valid held high.
    last_acc = -1;
    b2b = 1'b1;
    for (int k = 0; k < 4; k++)
      send(k % 3, 200 * k - 900, 50, 12000, 900, 7, 5, (k != 3), 1'b1, 1'b0, 0);
    drain();
    b2b = 1'b0;

    // Bad channel: accepted, no result, ready again two cycles after accept.
    send(3, -5000, 1000, 30000, 2000, 7, 15, 1'b0, 1'b1, 1'b0, 0);
    @(negedge clk);
    chk("bad_ch_busy", in_ready, 0);
    @(negedge clk);
    chk("bad_ch_ready", in_ready, 1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    // ch0 state untouched by the bad request.
    send(0, -1000, 0, 8192, 1024, 7, 3, 1'b0, 1'b1, 1'b0, 0);

    // vol=0: silent output, state still advances, sat flag cleared.
    send(0, 0, 0, 8192, 1024, 0, 0, 1'b0, 1'b1, 1'b1, 0);
    send(0, 0, 0, 8192, 1024, 7, 1, 1'b0, 1'b1, 1'b0, 0);
    drain();
    chk_sat("sat_after_vol0");

    repeat (10) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
